// File: rtl/serial_cmp_pkg.sv
// Shared types and defaults for the serial compare sequencer and its word shifters.
package serial_cmp_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT
    } seq_state_t;

endpackage

// File: rtl/serial_word_shifter.sv
// W-bit register that loads a word in parallel and streams it out MSB first.
module serial_word_shifter
    import serial_cmp_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] data;

    // A load takes priority so a new word can replace the final bit of the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= {data[W-2:0], 1'b0};
        end
    end

    assign msb = data[W-1];

endmodule

// File: rtl/serial_compare_sequencer.sv
// Accepts word pairs, clears the external MSB-first comparator, streams both words
// bit-serially and captures the comparator verdict on the last bit.
module serial_compare_sequencer
    import serial_cmp_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_word,
    input  logic [W-1:0] b_word,
    output logic         cmp_clear,
    output logic         out_valid,
    output logic         a,
    output logic         b,
    output logic         first,
    output logic         last,
    input  logic         cmp_less,
    input  logic         cmp_eq,
    input  logic         cmp_greater,
    output logic         res_valid,
    output logic         res_less,
    output logic         res_eq,
    output logic         res_greater
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    seq_state_t state, state_next;
    logic [CW-1:0] cnt;
    logic accept;
    logic shift_en;
    logic at_last;
    logic a_msb, b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cmp_clear  = 1'b0;
        out_valid  = 1'b0;
        first      = 1'b0;
        last       = 1'b0;
        shift_en   = 1'b0;
        at_last    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                cmp_clear  = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                shift_en  = 1'b1;
                first     = (cnt == '0);
                at_last   = (cnt == LAST_CNT);
                last      = at_last;
                // The LSB cycle doubles as an accept slot to keep W+1 cycles per pair.
                if (at_last) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? CLEAR : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR || at_last) begin
            cnt <= '0;
        end else if (state == SHIFT) begin
            cnt <= cnt + 1'b1;
        end
    end

    serial_word_shifter #(.W(W)) u_shift_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .din   (a_word),
        .msb   (a_msb)
    );

    serial_word_shifter #(.W(W)) u_shift_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .din   (b_word),
        .msb   (b_msb)
    );

    assign a = out_valid & a_msb;
    assign b = out_valid & b_msb;

    // The comparator outputs only carry the full-word verdict while the LSB is on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_less    <= 1'b0;
            res_eq      <= 1'b0;
            res_greater <= 1'b0;
        end else begin
            res_valid <= at_last;
            if (at_last) begin
                res_less    <= cmp_less;
                res_eq      <= cmp_eq;
                res_greater <= cmp_greater;
            end
        end
    end

endmodule

// File: doc/serial_compare_sequencer.md
Name: serial_compare_sequencer

Overview:
- Upstream/downstream wrapper for the MSB-first serial comparator.
- Accepts a pair of W-bit words over a valid/ready handshake.
- Pulses a clear to the comparator, then streams both words out one bit per cycle, MSB first.
- Captures the comparator's less/eq/greater outputs on the last bit and presents them as a one-cycle result strobe.

Parameters:
- W, 8, word width in bits; legal range 2..32.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  word pair available
- in_ready  out  1  block can accept a pair this cycle
- a_word  in  W  operand A, sampled on in_valid & in_ready
- b_word  in  W  operand B, sampled on in_valid & in_ready
- cmp_clear  out  1  drives the comparator rst; one-cycle pulse before the first bit
- out_valid  out  1  serial bits valid this cycle
- a  out  1  current bit of A (MSB first); 0 when out_valid=0
- b  out  1  current bit of B (MSB first); 0 when out_valid=0
- first  out  1  high with the MSB bit
- last  out  1  high with the LSB bit
- cmp_less  in  1  comparator a_less_b, combinational from current a/b
- cmp_eq  in  1  comparator a_eq_b
- cmp_greater  in  1  comparator a_greater_b
- res_valid  out  1  one-cycle result strobe
- res_less  out  1  captured result; held until the next capture
- res_eq  out  1  captured result; held until the next capture
- res_greater  out  1  captured result; held until the next capture

Behaviour:
- FSM states: IDLE, CLEAR, SHIFT. Bit counter width $clog2(W), counts 0..W-1. Two W-bit shift registers shift left; the MSB is the output bit.
- Reset: state=IDLE, counter=0, shift registers=0, cmp_clear=0, out_valid=0, first=0, last=0, res_valid=0, res_less=0, res_eq=0, res_greater=0.
- in_ready: high in IDLE, and in SHIFT when counter==W-1. Low otherwise.
- IDLE: on in_valid (acceptance), load both shift registers and go to CLEAR. Otherwise stay.
- CLEAR (one cycle):
  - cmp_clear=1, out_valid=0.
  - Next state SHIFT, counter=0.
- SHIFT:
  - out_valid=1; a/b are the shift-register MSBs.
  - first=(counter==0); last=(counter==W-1).
  - Each cycle, shift left by one and increment the counter.
- At counter==W-1:
  - Register cmp_less, cmp_eq and cmp_greater into the res_* outputs.
  - res_valid=1 in the following cycle only.
  - Next state is CLEAR with the new words loaded if a handshake occurs this cycle, else IDLE.
- Back-to-back throughput: W+1 cycles per pair.
- Latency: acceptance edge at T gives cmp_clear in cycle T+1, the MSB in T+2, the LSB in T+W+1, and res_valid in T+W+2.
- res_valid of pair N may coincide with cmp_clear of pair N+1; this is legal.
- in_valid with in_ready=0: ignored. The source must hold its data; the block does not buffer.
- Reset mid-word: immediate return to IDLE. No res_valid for the aborted pair; res_* values are cleared.
- Reset has priority over a handshake in the same cycle.
- The cmp_* inputs are ignored except in the last SHIFT cycle.

Decomposition:
- Package serial_cmp_pkg:
  - enum seq_state_t {IDLE, CLEAR, SHIFT}
  - localparam DEFAULT_W=8
- One sub-module: serial_word_shifter.
  - W-bit load/shift-left register with an msb output.
  - Instantiated twice, once for A and once for B.
- FSM, counter and result capture stay in the top module.

Test Plan (W=4; comparator instantiated and wired to cmp_clear/a/b):
- Reset, then idle 3 cycles -> in_ready=1; all other outputs 0; res_valid never asserts.
- A=1010, B=1001, handshake at edge T -> cmp_clear in T+1; (a,b)=(1,1),(0,0),(1,0),(0,1) in T+2..T+5; first at T+2, last at T+5; res_valid at T+6 with res_greater=1 only.
- A=0111, B=1000 -> res_less=1. Then A=B=0110 -> res_eq=1. Then A=B=0000 -> res_eq=1.
- in_valid held high with pairs (0011,0010), (0001,0010) -> in_ready high during the last SHIFT cycle; second cmp_clear directly follows the first LSB; results greater then less; 5-cycle spacing between res_valid pulses.
- rst asserted at the second SHIFT cycle -> next cycle out_valid=0, state IDLE, res_valid stays 0; a new pair afterwards produces a correct result.
- in_valid asserted during CLEAR/SHIFT (not last) -> not accepted, in_ready=0; the data is accepted only when in_ready rises.
